onchip_ram_arbiter: RTL

//  Two-master Avalon-MM arbiter sharing one single-port on-chip RAM (2048x32, byte-enabled, 1-cycle read latency).

---
 rtl/onchip_ram_arbiter_if.sv | 43 ++++
 rtl/onchip_ram_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/onchip_ram_arbiter_if.sv
// rtl/onchip_ram_arbiter_if.sv - Avalon-MM master bus bundle used by the on-chip RAM arbiter
//
// Purpose
//    Groups one Avalon-MM master's request/response signals so each master of
//    the arbiter is a single port.
//
// Signals
//    address        master -> slave  ADDR_W  word address
//    read           master -> slave  1       read request
//    write          master -> slave  1       write request (wins over read if both high)
//    byteenable     master -> slave  BE_W    byte lanes
//    writedata      master -> slave  DATA_W  write data
//    waitrequest    slave -> master  1       1 = request not accepted this cycle
//    readdata       slave -> master  DATA_W  read data
//    readdatavalid  slave -> master  1       readdata valid this cycle
//
// Modports
//    master  : the requesting side (CPU data master, DMA)
//    slave   : the arbiter side
interface onchip_ram_arbiter_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32,
   parameter int BE_W   = 4
);
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [BE_W-1:0]   byteenable;
   logic [DATA_W-1:0] writedata;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output address, read, write, byteenable, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, byteenable, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/onchip_ram_arbiter.sv
// rtl/onchip_ram_arbiter.sv - two-master Avalon-MM arbiter in front of a single-port on-chip RAM
//
// Purpose
//    Shares one 2048x32 byte-enabled single-port RAM (1-cycle read latency)
//    between master 0 (CPU data master) and master 1 (DMA/peripheral master).
//    At most one RAM access is issued per clock; read data is returned to the
//    master that issued the read, one cycle after acceptance, with readdatavalid.
//
// Ports
//    clk             in   1       system clock
//    reset_n         in   1       asynchronous reset, active-low
//    m0              slave        master 0 bus (onchip_ram_arbiter_if)
//    m1              slave        master 1 bus (onchip_ram_arbiter_if)
//    ram_address     out  ADDR_W  RAM word address
//    ram_chipselect  out  1       RAM access strobe
//    ram_write       out  1       RAM write enable
//    ram_byteenable  out  BE_W    RAM byte lanes
//    ram_writedata   out  DATA_W  RAM write data
//    ram_clken       out  1       RAM clock enable, high once out of reset
//    ram_readdata    in   DATA_W  RAM read data, valid the cycle after a read
//
// Configuration
//    ONCHIP_ARB_FIXED_PRIO_EN  defined   : master 0 always wins a contest
//                              undefined : round-robin between the masters
module onchip_ram_arbiter #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32,
   parameter int BE_W   = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   onchip_ram_arbiter_if.slave m0,
   onchip_ram_arbiter_if.slave m1,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic [BE_W-1:0]   ram_byteenable,
   output logic [DATA_W-1:0] ram_writedata,
   output logic              ram_clken,
   input  logic [DATA_W-1:0] ram_readdata
);

   // Wake-up sequencing: hold everything off for the first clock after reset
   typedef enum logic {
      ST_WAKE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   rdy;

   logic   last_gnt;   // index of the master granted most recently
   logic   rd_vld;     // a read was accepted on the previous edge
   logic   rd_own;     // which master that read belongs to

   logic   req0;
   logic   req1;
   logic   any_req;
   logic   sel;        // winning master index when any_req
   logic   acc;        // an access is issued to the RAM this cycle
   logic   win_read;
   logic   win_write;
   logic   acc_rd;

   // ------------------------------------------------------------------
   // Wake-up FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_WAKE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (state == ST_WAKE) begin
         state_nxt = ST_RUN;
      end
   end

   assign rdy = (state == ST_RUN);

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
   assign req0    = m0.read | m0.write;
   assign req1    = m1.read | m1.write;
   assign any_req = req0 | req1;

   always_comb begin
      sel = 1'b0;
      if (req0 && req1) begin
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
         sel = 1'b0;
`else
         // The master that did not win last time gets this one
         sel = ~last_gnt;
`endif
      end else begin
         sel = req1;
      end
   end

   assign acc = rdy & any_req;

   assign m0.waitrequest = ~(acc & ~sel);
   assign m1.waitrequest = ~(acc &  sel);

   // ------------------------------------------------------------------
   // RAM request mux
   // ------------------------------------------------------------------
   assign win_read  = sel ? m1.read  : m0.read;
   assign win_write = sel ? m1.write : m0.write;

   // A simultaneous read+write is treated as a write and returns no data
   assign acc_rd = acc & win_read & ~win_write;

   assign ram_address    = sel ? m1.address    : m0.address;
   assign ram_byteenable = sel ? m1.byteenable : m0.byteenable;
   assign ram_writedata  = sel ? m1.writedata  : m0.writedata;
   assign ram_chipselect = acc;
   assign ram_write      = acc & win_write;
   assign ram_clken      = rdy;

   // ------------------------------------------------------------------
   // Grant history and read-return tracking
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_gnt <= 1'b1;   // so master 0 wins the first contest
         rd_vld   <= 1'b0;
         rd_own   <= 1'b0;
      end else begin
         if (acc) begin
            last_gnt <= sel;
         end
         rd_vld <= acc_rd;
         if (acc_rd) begin
            rd_own <= sel;
         end
      end
   end

   // Read data is broadcast; only readdatavalid is steered to the owner
   assign m0.readdata      = ram_readdata;
   assign m1.readdata      = ram_readdata;
   assign m0.readdatavalid = rd_vld & ~rd_own;
   assign m1.readdatavalid = rd_vld &  rd_own;

endmodule
